// File: rtl/ab_pkg.sv
// Shared types and evaluation functions for the A/B function-unit arbiter.
package ab_pkg;

    typedef enum logic [1:0] {
        OP_A    = 2'd0,
        OP_B    = 2'd1,
        OP_TOP  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    function automatic logic ab_eval_a(input logic x, input logic y);
        return x & ~y;
    endfunction

    function automatic logic ab_eval_b(input logic x, input logic y);
        return ~(x ^ y);
    endfunction

    // Built literally from A and B; it reduces to x | ~y.
    function automatic logic ab_eval_top(input logic x, input logic y);
        logic a;
        logic b;
        a = ab_eval_a(x, y);
        b = ab_eval_b(x, y);
        return (a | b) ^ (a & b);
    endfunction

endpackage

// File: rtl/ab_rr_arbiter.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module ab_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last_grant) + k) % NREQ);
            if (en && !grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ab_eval_arbiter.sv
// Round-robin sharing of one A/B evaluation unit with a one-entry output slot.
module ab_eval_arbiter
    import ab_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_x,
    input  logic [NREQ-1:0]   req_y,
    input  logic [2*NREQ-1:0] req_op,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_z,
    output logic              rsp_err,
    output logic [CNTW-1:0]   issue_count,
    output logic              fsm_state
);

    // Handshake: a request moves when req_valid[i] && req_ready[i] at a rising
    // edge; a response moves when rsp_valid && rsp_ready at a rising edge.

    state_e         state;
    state_e         state_next;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] grant_idx;
    logic [NREQ-1:0] grant;
    logic           grant_any;
    logic           slot_free;
    logic           sel_x;
    logic           sel_y;
    op_e            sel_op;
    logic           eval_z;
    logic           eval_err;

    assign rsp_valid = (state == ST_FULL);
    assign slot_free = !rsp_valid || rsp_ready;
    assign req_ready = grant;
    assign fsm_state = state;

    // Reset gates the enable so no grant is offered while reset is held.
    ab_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req        (req_valid),
        .en         (enable && slot_free && !reset),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    always_comb begin
        sel_x  = 1'b0;
        sel_y  = 1'b0;
        sel_op = OP_A;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_x  = req_x[i];
                sel_y  = req_y[i];
                sel_op = op_e'(req_op[2*i +: 2]);
            end
        end
    end

    always_comb begin
        eval_z   = 1'b0;
        eval_err = 1'b0;
        case (sel_op)
            OP_A:    eval_z = ab_eval_a(sel_x, sel_y);
            OP_B:    eval_z = ab_eval_b(sel_x, sel_y);
            OP_TOP:  eval_z = ab_eval_top(sel_x, sel_y);
            default: eval_err = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (grant_any) state_next = ST_FULL;
            ST_FULL:  if (rsp_ready && !grant_any) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_EMPTY;
            rsp_id      <= '0;
            rsp_z       <= 1'b0;
            rsp_err     <= 1'b0;
            issue_count <= '0;
            last_grant  <= IDW'(NREQ - 1);
        end else begin
            state <= state_next;
            if (grant_any) begin
                rsp_id      <= grant_idx;
                rsp_z       <= eval_z;
                rsp_err     <= eval_err;
                last_grant  <= grant_idx;
                issue_count <= issue_count + 1'b1;
            end
        end
    end

endmodule
